uart_pkt_parser: RTL and testbench
==================================

Name: uart_pkt_parser

Overview:
Parametrised UART command-frame parser for the video-process control path. Consumes the byte stream from the UART receiver and validates framed packets: header, type, explicit length, payload, checksum and trailer. Delivers the payload with a type tag to the control registers. Reports framing, length, checksum and timeout errors, and keeps the registered byte echo towards the UART transmitter.

Parameters:
MAX_BYTES, 27, maximum payload bytes per packet (1..255); sets pkt_data width
HDR0_BYTE, 8'h00, first header byte
HDR1_NIB, 4'hF, required upper nibble of the second header byte; the lower nibble is the packet type
END0_BYTE, 8'hFF, first trailer byte
END1_BYTE, 8'h00, second trailer byte
TIMEOUT_CYCLES, 24'h2932E0, idle clocks inside a packet before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
tx_valid  out  1  echo strobe (rx_valid delayed 1 clk)
tx_data  out  8  echo byte (rx_data delayed 1 clk)
pkt_valid  out  1  one-cycle pulse, packet accepted
pkt_type  out  4  type nibble of the accepted packet
pkt_len  out  8  payload byte count of the accepted packet
pkt_data  out  MAX_BYTES*8  payload; first received byte at [7:0]; unused upper bytes zero
err_len  out  1  pulse: length byte is 0 or greater than MAX_BYTES
err_csum  out  1  pulse: checksum mismatch
err_end  out  1  pulse: bad trailer byte
err_timeout  out  1  pulse: inter-byte timeout
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; counters, payload buffer and checksum cleared.
- Bytes are consumed only on rx_valid. tx_valid and tx_data register rx_valid and rx_data every clock, independent of state.
- Frame: HDR0, HDR1 (upper nibble HDR1_NIB, lower nibble type), LEN, LEN payload bytes, CSUM, END0, END1.
- CSUM is the 8-bit modulo-256 sum of the HDR1 byte, the LEN byte and all payload bytes.
- States and transitions:
  - IDLE: on HDR0_BYTE, go to HDR1; clear the checksum and byte counter.
  - HDR1: on a byte with a matching nibble, latch the type, seed the checksum with the byte, go to LEN. On HDR0_BYTE, stay in HDR1 (resync). Any other byte returns to IDLE with no error pulse.
  - LEN: if the value is 0 or greater than MAX_BYTES, pulse err_len and go to IDLE. Otherwise latch the value, add it to the checksum, and go to DATA.
  - DATA: write each byte into slot byte_cnt of the shadow buffer and accumulate the checksum. After the LEN-th byte, go to CSUM. The shadow buffer is cleared on entry to DATA.
  - CSUM: if the byte equals the accumulated sum, go to END0; otherwise pulse err_csum and go to IDLE.
  - END0: if the byte is END0_BYTE, go to END1; otherwise pulse err_end and go to IDLE.
  - END1: if the byte is END1_BYTE, go to DONE; otherwise pulse err_end and go to IDLE.
  - DONE: one cycle. Copy the shadow buffer to pkt_data, the type to pkt_type and the length to pkt_len. Go to IDLE.
- Packet timing: pkt_valid rises 2 clocks after the END1 byte is sampled and lasts 1 clock. pkt_data, pkt_type and pkt_len update in the same cycle and hold until the next accepted packet; error paths never modify them.
- All error pulses are 1 clock, registered. At most one error pulse per frame.
- Timeout: the counter runs when the state is not IDLE and not DONE, and clears on every rx_valid and in IDLE. When it reaches TIMEOUT_CYCLES-1 with no rx_valid, pulse err_timeout and force IDLE. If rx_valid arrives in that same cycle, the byte wins and no timeout occurs.
- Async reset mid-packet: the frame is discarded, all outputs return to 0, and no pulses are emitted.
- Widths: byte_cnt and LEN are 8 bits. Payload slot index is byte_cnt, and is always less than MAX_BYTES because LEN is validated first.

Decomposition:
- Shared package uart_pkt_pkg holds the state encoding (IDLE, HDR1, LEN, DATA, CSUM, END0, END1, DONE), default frame bytes and the timeout default, for reuse by a future uart_pkt_builder on the TX side.
- One sub-module, uart_rx_timeout: counter with enable, clear and TIMEOUT_CYCLES parameter, producing a single-cycle expiry pulse.

Test Plan:
- Good packet: bytes 00 F1 02 AA 55 F2 FF 00 -> pkt_valid once; pkt_type=1, pkt_len=2, pkt_data[15:0]=16'h55AA, upper bits 0; no error pulses; tx echo matches every byte 1 clock later.
- Bad checksum: 00 F1 02 AA 55 F3 -> err_csum pulse; pkt_data keeps its previous value; next good packet is accepted.
- Length bounds: LEN=00 -> err_len; LEN=MAX_BYTES+1 -> err_len; LEN=MAX_BYTES with a correct checksum -> pkt_valid with all MAX_BYTES slots filled and byte 0 at [7:0].
- Timeout: 00 F1 02 AA, then idle for TIMEOUT_CYCLES clocks -> exactly one err_timeout pulse, busy falls; a following good packet is accepted. A byte arriving at count TIMEOUT_CYCLES-1 -> no timeout.
- Resync and trailer: 00 00 F0 01 7E 6F FF 00 (sum F0+01+7E=16F -> 6F) -> the repeated header is tolerated, pkt_valid fires with pkt_type=0, pkt_data[7:0]=7E. The same frame with END1=01 -> err_end, no pkt_valid.
- Reset: assert rst_n low during the DATA state -> all outputs 0 immediately; after release, a good packet parses normally.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART command-frame path: parser state encoding,
// default frame delimiters and timeout, reusable by a TX-side frame builder.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_END0,
        ST_END1,
        ST_DONE
    } state_e;

    localparam int          DEF_MAX_BYTES      = 27;
    localparam logic [7:0]  DEF_HDR0_BYTE      = 8'h00;
    localparam logic [3:0]  DEF_HDR1_NIB       = 4'hF;
    localparam logic [7:0]  DEF_END0_BYTE      = 8'hFF;
    localparam logic [7:0]  DEF_END1_BYTE      = 8'h00;
    localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'h2932E0;

    // Checksum is a plain modulo-256 sum; the carry is deliberately dropped.
    function automatic logic [7:0] csumAdd(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte watchdog: counts enabled idle clocks and emits a one-cycle
// expiry pulse when TIMEOUT_CYCLES-1 is reached without a clear.
module uart_rx_timeout
    import uart_pkt_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic        hit;

    assign hit = (cnt_q == (TIMEOUT_CYCLES - 24'd1));

    // A clear always wins over expiry, so a byte arriving on the last count
    // keeps the frame alive.
    assign expire_o = en_i & ~clr_i & hit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = hit ? 24'd0 : cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_pkt_parser.sv
// Framed command parser: HDR0, HDR1|type, LEN, payload, CSUM, END0, END1.
// Delivers validated payloads and one-cycle error pulses; echoes rx bytes.
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter int          MAX_BYTES      = DEF_MAX_BYTES,
    parameter logic [7:0]  HDR0_BYTE      = DEF_HDR0_BYTE,
    parameter logic [3:0]  HDR1_NIB       = DEF_HDR1_NIB,
    parameter logic [7:0]  END0_BYTE      = DEF_END0_BYTE,
    parameter logic [7:0]  END1_BYTE      = DEF_END1_BYTE,
    parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_data_i,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    output logic                   pkt_valid_o,
    output logic [3:0]             pkt_type_o,
    output logic [7:0]             pkt_len_o,
    output logic [MAX_BYTES*8-1:0] pkt_data_o,
    output logic                   err_len_o,
    output logic                   err_csum_o,
    output logic                   err_end_o,
    output logic                   err_timeout_o,
    output logic                   busy_o
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

    state_e state_q;
    state_e state_d;

    logic [3:0]             type_q,    type_d;
    logic [7:0]             len_q,     len_d;
    logic [7:0]             cnt_q,     cnt_d;
    logic [7:0]             csum_q,    csum_d;
    logic [MAX_BYTES*8-1:0] shadow_q,  shadow_d;

    logic [3:0]             pktType_q, pktType_d;
    logic [7:0]             pktLen_q,  pktLen_d;
    logic [MAX_BYTES*8-1:0] pktData_q, pktData_d;

    logic pktValid_q,   pktValid_d;
    logic errLen_q,     errLen_d;
    logic errCsum_q,    errCsum_d;
    logic errEnd_q,     errEnd_d;
    logic errTimeout_q, errTimeout_d;

    logic       txValid_q;
    logic [7:0] txData_q;

    logic nibOk;
    logic lenBad;
    logic lastData;
    logic tmoEn;
    logic tmoClr;
    logic tmoHit;

    assign nibOk    = (rx_data_i[7:4] == HDR1_NIB);
    assign lenBad   = (rx_data_i == 8'd0) || (rx_data_i > MAX_LEN);
    assign lastData = (cnt_q == (len_q - 8'd1));

    assign tmoEn  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign tmoClr = rx_valid_i || (state_q == ST_IDLE);

    uart_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (tmoEn),
        .clr_i   (tmoClr),
        .expire_o(tmoHit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && (rx_data_i == HDR0_BYTE)) state_d = ST_HDR1;
            end
            ST_HDR1: begin
                if (rx_valid_i) begin
                    if (nibOk)                         state_d = ST_LEN;
                    else if (rx_data_i == HDR0_BYTE)   state_d = ST_HDR1;
                    else                               state_d = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (rx_valid_i) state_d = lenBad ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (rx_valid_i && lastData) state_d = ST_CSUM;
            end
            ST_CSUM: begin
                if (rx_valid_i) state_d = (rx_data_i == csum_q) ? ST_END0 : ST_IDLE;
            end
            ST_END0: begin
                if (rx_valid_i) state_d = (rx_data_i == END0_BYTE) ? ST_END1 : ST_IDLE;
            end
            ST_END1: begin
                if (rx_valid_i) state_d = (rx_data_i == END1_BYTE) ? ST_DONE : ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (tmoHit) state_d = ST_IDLE;
    end

    // Each error cause lives in exactly one state, so a frame can raise at most one pulse.
    always_comb begin
        pktValid_d   = (state_q == ST_DONE);
        errLen_d     = (state_q == ST_LEN)  && rx_valid_i && lenBad;
        errCsum_d    = (state_q == ST_CSUM) && rx_valid_i && (rx_data_i != csum_q);
        errEnd_d     = ((state_q == ST_END0) && rx_valid_i && (rx_data_i != END0_BYTE)) ||
                       ((state_q == ST_END1) && rx_valid_i && (rx_data_i != END1_BYTE));
        errTimeout_d = tmoHit;
    end

    always_comb begin
        type_d    = type_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        shadow_d  = shadow_q;
        pktType_d = pktType_q;
        pktLen_d  = pktLen_q;
        pktData_d = pktData_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && (rx_data_i == HDR0_BYTE)) begin
                    csum_d = '0;
                    cnt_d  = '0;
                end
            end
            ST_HDR1: begin
                if (rx_valid_i && nibOk) begin
                    type_d = rx_data_i[3:0];
                    csum_d = rx_data_i;
                end
            end
            ST_LEN: begin
                if (rx_valid_i && !lenBad) begin
                    len_d    = rx_data_i;
                    csum_d   = csumAdd(csum_q, rx_data_i);
                    shadow_d = '0;
                    cnt_d    = '0;
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        if (cnt_q == 8'(i)) shadow_d[i*8 +: 8] = rx_data_i;
                    end
                    csum_d = csumAdd(csum_q, rx_data_i);
                    cnt_d  = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                pktData_d = shadow_q;
                pktType_d = type_q;
                pktLen_d  = len_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            type_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            csum_q       <= '0;
            shadow_q     <= '0;
            pktType_q    <= '0;
            pktLen_q     <= '0;
            pktData_q    <= '0;
            pktValid_q   <= 1'b0;
            errLen_q     <= 1'b0;
            errCsum_q    <= 1'b0;
            errEnd_q     <= 1'b0;
            errTimeout_q <= 1'b0;
            txValid_q    <= 1'b0;
            txData_q     <= '0;
        end else begin
            type_q       <= type_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            shadow_q     <= shadow_d;
            pktType_q    <= pktType_d;
            pktLen_q     <= pktLen_d;
            pktData_q    <= pktData_d;
            pktValid_q   <= pktValid_d;
            errLen_q     <= errLen_d;
            errCsum_q    <= errCsum_d;
            errEnd_q     <= errEnd_d;
            errTimeout_q <= errTimeout_d;
            txValid_q    <= rx_valid_i;
            txData_q     <= rx_data_i;
        end
    end

    assign tx_valid_o    = txValid_q;
    assign tx_data_o     = txData_q;
    assign pkt_valid_o   = pktValid_q;
    assign pkt_type_o    = pktType_q;
    assign pkt_len_o     = pktLen_q;
    assign pkt_data_o    = pktData_q;
    assign err_len_o     = errLen_q;
    assign err_csum_o    = errCsum_q;
    assign err_end_o     = errEnd_q;
    assign err_timeout_o = errTimeout_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser: a frame table plus hand-written
// sequences for pulse timing, maximum length, timeout and mid-frame reset.
module tb_uart_pkt_parser;

    localparam int          MAXB = 27;
    localparam int          DW   = MAXB * 8;
    localparam logic [23:0] TMO  = 24'd20;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          pkt_valid;
    logic [3:0]    pkt_type;
    logic [7:0]    pkt_len;
    logic [DW-1:0] pkt_data;
    logic          err_len, err_csum, err_end, err_timeout, busy;

    always #5 clk = ~clk;

    uart_pkt_parser #(
        .MAX_BYTES     (MAXB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .tx_valid_o   (tx_valid),
        .tx_data_o    (tx_data),
        .pkt_valid_o  (pkt_valid),
        .pkt_type_o   (pkt_type),
        .pkt_len_o    (pkt_len),
        .pkt_data_o   (pkt_data),
        .err_len_o    (err_len),
        .err_csum_o   (err_csum),
        .err_end_o    (err_end),
        .err_timeout_o(err_timeout),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [95:0] bytes;
        logic [7:0]  n;
        logic        expPkt;
        logic        expLen;
        logic        expCsum;
        logic        expEnd;
        logic [3:0]  expType;
        logic [7:0]  expPktLen;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs [9];

    int checks = 0;
    int errors = 0;
    int nPkt, nLen, nCsum, nEnd, nTmo, echoBad;
    logic       prevValid = 1'b0;
    logic [7:0] prevData  = 8'h00;

    // Pulse counters and the echo model sample on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevValid = 1'b0;
            prevData  = 8'h00;
        end else begin
            if (pkt_valid)   nPkt++;
            if (err_len)     nLen++;
            if (err_csum)    nCsum++;
            if (err_end)     nEnd++;
            if (err_timeout) nTmo++;
            if ((tx_valid !== prevValid) || (prevValid && (tx_data !== prevData))) echoBad++;
            prevValid = rx_valid;
            prevData  = rx_data;
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clearCounts();
        nPkt = 0; nLen = 0; nCsum = 0; nEnd = 0; nTmo = 0; echoBad = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [95:0] bytes, input int n);
        clearCounts();
        for (int i = 0; i < n; i++) sendByte(bytes[i*8 +: 8]);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic checkCounts(input string tag, input int ePkt, input int eLen,
                               input int eCsum, input int eEnd, input int eTmo);
        checkOutput({tag, ".pkt_valid_count"},   nPkt,    ePkt);
        checkOutput({tag, ".err_len_count"},     nLen,    eLen);
        checkOutput({tag, ".err_csum_count"},    nCsum,   eCsum);
        checkOutput({tag, ".err_end_count"},     nEnd,    eEnd);
        checkOutput({tag, ".err_timeout_count"}, nTmo,    eTmo);
        checkOutput({tag, ".echo_mismatches"},   echoBad, 0);
    endtask

    initial begin
        logic [DW-1:0] expMax;
        logic [63:0]   goodFrame;

        goodFrame = {8'h00, 8'hFF, 8'hF2, 8'h55, 8'hAA, 8'h02, 8'hF1, 8'h00};
        vecs[0] = '{bytes: 96'(goodFrame), n: 8, expPkt: 1, expLen: 0, expCsum: 0, expEnd: 0,
                    expType: 4'h1, expPktLen: 8'd2, expData: 16'h55AA};
        vecs[1] = '{bytes: 96'({8'hF3, 8'h55, 8'hAA, 8'h02, 8'hF1, 8'h00}), n: 6, expPkt: 0,
                    expLen: 0, expCsum: 1, expEnd: 0, expType: 4'h1, expPktLen: 8'd2, expData: 16'h55AA};
        vecs[2] = vecs[0];
        vecs[3] = '{bytes: 96'({8'h00, 8'hF1, 8'h00}), n: 3, expPkt: 0, expLen: 1, expCsum: 0,
                    expEnd: 0, expType: 4'h1, expPktLen: 8'd2, expData: 16'h55AA};
        vecs[4] = '{bytes: 96'({8'h1C, 8'hF1, 8'h00}), n: 3, expPkt: 0, expLen: 1, expCsum: 0,
                    expEnd: 0, expType: 4'h1, expPktLen: 8'd2, expData: 16'h55AA};
        vecs[5] = '{bytes: 96'({8'h00, 8'hFF, 8'h6F, 8'h7E, 8'h01, 8'hF0, 8'h00, 8'h00}), n: 8,
                    expPkt: 1, expLen: 0, expCsum: 0, expEnd: 0, expType: 4'h0, expPktLen: 8'd1,
                    expData: 16'h007E};
        vecs[6] = '{bytes: 96'({8'h01, 8'hFF, 8'h6F, 8'h7E, 8'h01, 8'hF0, 8'h00, 8'h00}), n: 8,
                    expPkt: 0, expLen: 0, expCsum: 0, expEnd: 1, expType: 4'h0, expPktLen: 8'd1,
                    expData: 16'h007E};
        vecs[7] = '{bytes: 96'({8'hFE, 8'h04, 8'h10, 8'h01, 8'hF3, 8'h00}), n: 6, expPkt: 0,
                    expLen: 0, expCsum: 0, expEnd: 1, expType: 4'h0, expPktLen: 8'd1, expData: 16'h007E};
        vecs[8] = '{bytes: 96'({8'hE1, 8'h00}), n: 2, expPkt: 0, expLen: 0, expCsum: 0, expEnd: 0,
                    expType: 4'h0, expPktLen: 8'd1, expData: 16'h007E};

        clearCounts();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.outputs",
                    {tx_valid, tx_data, pkt_valid, pkt_type, pkt_len, err_len, err_csum,
                     err_end, err_timeout, busy}, '0);
        checkOutput("reset.pkt_data", pkt_data, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Pulse timing: echo one clock after the byte, pkt_valid two clocks after END1.
        clearCounts();
        for (int i = 0; i < 8; i++) sendByte(goodFrame[i*8 +: 8]);
        checkOutput("timing.echo_end1", {tx_valid, tx_data}, {1'b1, 8'h00});
        checkOutput("timing.pkt_valid_early", pkt_valid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("timing.pkt_valid_high", pkt_valid, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("timing.pkt_valid_low", pkt_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkCounts("timing", 1, 0, 0, 0, 0);

        for (int v = 0; v < 9; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            applyStimulus(vecs[v].bytes, int'(vecs[v].n));
            checkCounts(tag, int'(vecs[v].expPkt), int'(vecs[v].expLen),
                        int'(vecs[v].expCsum), int'(vecs[v].expEnd), 0);
            checkOutput({tag, ".pkt_type"}, pkt_type, vecs[v].expType);
            checkOutput({tag, ".pkt_len"},  pkt_len,  vecs[v].expPktLen);
            checkOutput({tag, ".pkt_data"}, pkt_data, DW'(vecs[v].expData));
            checkOutput({tag, ".busy"},     busy,     1'b0);
        end

        // Maximum length: payload bytes 1..27, checksum F2+1B+378 = 0x287 -> 87.
        clearCounts();
        expMax = '0;
        sendByte(8'h00);
        sendByte(8'hF2);
        sendByte(8'(MAXB));
        for (int i = 0; i < MAXB; i++) begin
            sendByte(8'(i + 1));
            expMax[i*8 +: 8] = 8'(i + 1);
        end
        sendByte(8'h87);
        sendByte(8'hFF);
        sendByte(8'h00);
        repeat (6) @(posedge clk);
        #1;
        checkCounts("maxlen", 1, 0, 0, 0, 0);
        checkOutput("maxlen.pkt_type", pkt_type, 4'h2);
        checkOutput("maxlen.pkt_len",  pkt_len,  8'(MAXB));
        checkOutput("maxlen.pkt_data", pkt_data, expMax);

        // Idle for TMO clocks inside DATA aborts the frame exactly once.
        clearCounts();
        sendByte(8'h00); sendByte(8'hF1); sendByte(8'h02); sendByte(8'hAA);
        repeat (18) @(posedge clk);
        #1;
        checkOutput("tmo.busy_before", busy, 1'b1);
        checkOutput("tmo.count_before", nTmo, 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("tmo.count_after", nTmo, 1);
        checkOutput("tmo.busy_after", busy, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checkCounts("tmo", 0, 0, 0, 0, 1);
        checkOutput("tmo.pkt_data_held", pkt_data, expMax);
        applyStimulus(96'(goodFrame), 8);
        checkCounts("tmo_recover", 1, 0, 0, 0, 0);
        checkOutput("tmo_recover.pkt_data", pkt_data, DW'(16'h55AA));

        // A byte landing on the last timeout count keeps the frame alive.
        clearCounts();
        sendByte(8'h00); sendByte(8'hF1); sendByte(8'h02); sendByte(8'hAA);
        repeat (19) @(posedge clk);
        #1;
        sendByte(8'h55); sendByte(8'hF2); sendByte(8'hFF); sendByte(8'h00);
        repeat (6) @(posedge clk);
        #1;
        checkCounts("tmo_edge", 1, 0, 0, 0, 0);

        // Asynchronous reset in the middle of DATA.
        clearCounts();
        sendByte(8'h00); sendByte(8'hF1); sendByte(8'h05); sendByte(8'h11); sendByte(8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset.outputs",
                    {tx_valid, tx_data, pkt_valid, pkt_type, pkt_len, err_len, err_csum,
                     err_end, err_timeout, busy}, '0);
        checkOutput("midreset.pkt_data", pkt_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearCounts();
        repeat (30) @(posedge clk);
        #1;
        checkCounts("midreset_quiet", 0, 0, 0, 0, 0);
        applyStimulus(96'(goodFrame), 8);
        checkCounts("midreset_recover", 1, 0, 0, 0, 0);
        checkOutput("midreset_recover.pkt_data", pkt_data, DW'(16'h55AA));
        checkOutput("midreset_recover.pkt_type", pkt_type, 4'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
